sm_ram_arbiter: RTL
===================

// Module: sm_ram_arbiter
// PURPOSE
//  Shares the single-port data RAM (sm_ram, synchronous 1-cycle read) between two requesters:
//  port 0 = CPU load/store unit, port 1 = debug/loader master. Round-robin arbitration,
//  one access per cycle, back-to-back capable; returns read data to the owning port.
//  Sits between sm_cpu's data-access logic and sm_ram; sm_ram itself is unchanged.
// PARAMETERS
//  AW     32  word-address width driven to the RAM
//  DW     32  data width
//  CNT_W  16  width of each grant counter (only with SM_RAM_ARB_PERF_EN)
// PORTS
//  clk        in   1   clock; all state on rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  m0_req     in   1   port 0 access request; held with its fields stable until m0_gnt
//  m0_we      in   1   port 0 write (1) / read (0)
//  m0_addr    in   AW  port 0 word address
//  m0_wdata   in   DW  port 0 write data
//  m0_gnt     out  1   port 0 request accepted this cycle (combinational)
//  m0_rvalid  out  1   port 0 read data valid (registered)
//  m0_rdata   out  DW  port 0 read data
//  m1_*       --   --  identical set for port 1
//  ram_addr   out  AW  to sm_ram addr_a
//  ram_wdata  out  DW  to sm_ram data_a
//  ram_we     out  1   to sm_ram we_a
//  ram_rdata  in   DW  from sm_ram q_a (valid the cycle after the address)
// BEHAVIOUR
//  - Grant: exactly one of m0_gnt/m1_gnt high when any req high, same cycle as req.
//    Single req -> granted at once. Both req -> port NOT equal to last_owner wins.
//  - last_owner (1 bit): updated to the granted port on every grant; reset value 1,
//    so port 0 wins the first conflict. Neither port waits more than one grant.
//  - RAM drive: ram_addr/ram_wdata/ram_we = fields of granted port; no grant ->
//    ram_we=0, ram_addr/ram_wdata = port 0 fields (don't-care, no write).
//  - Read pipeline: on a read grant register rd_pend=1, rd_owner=port. Next cycle
//    mX_rvalid=1 for rd_owner only, mX_rdata = ram_rdata. Latency: gnt -> rvalid = 1 cycle.
//    Reads may issue every cycle, alternating owners allowed; no stall.
//  - Writes: complete at the gnt edge; no rvalid generated.
//  - mX_rdata of non-owning port = 0 (no data leakage between ports).
//  - No forwarding: write at cycle N then read same address at N+1 returns new data
//    (sm_ram ordering); same-cycle read/write conflict impossible (one grant/cycle).
//  - Reset (async assert, any time): rd_pend=0, rd_owner=0, last_owner=1, counters=0;
//    m*_rvalid=0 and m*_rdata=0 immediately; m*_gnt and ram_we forced 0 while rst_n=0.
//    A read granted in the cycle reset asserts is dropped (no rvalid after release).
//  - Requester rule: deasserting req before gnt is legal (withdraw); changing fields
//    while req high and not granted is illegal (assertion in bench).
// CONFIGURATION
//  SM_RAM_ARB_PERF_EN defined: adds ports perf_clr(in,1), perf_gnt0(out,CNT_W),
//    perf_gnt1(out,CNT_W), perf_wait(out,CNT_W). gnt0/gnt1 count grants per port;
//    wait counts cycles with a req high but not granted. All saturate at all-ones;
//    perf_clr zeroes all three synchronously (clr wins over increment same cycle).
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared header sm_cpu.vh: `SM_ARB_PORT0 (1'b0), `SM_ARB_PORT1 (1'b1) owner codes,
//    `SM_ARB_LAST_RST (=`SM_ARB_PORT1).
//  - One sub-module: sm_arb_rr2 (2-way round-robin: req[1:0] -> gnt[1:0], holds
//    last_owner flop). Read-return pipeline and counters stay in the top module.
// TESTING
//  1 Reset: rst_n=0 mid-read (m0 read gnt at same edge) -> rvalid never asserts,
//    ram_we=0, outputs 0; first conflict after release grants port 0.
//  2 Single port: m0 write addr 5 data 32'hDEAD_BEEF, then m0 read addr 5 ->
//    m0_gnt same cycle each, m0_rvalid one cycle after read gnt, m0_rdata=32'hDEAD_BEEF,
//    m1_rvalid=0.
//  3 Conflict: m0,m1 both read continuously (addr 1 / addr 2 preloaded 11/22) ->
//    grants alternate 0,1,0,1; rvalid alternates with rdata 11,22,11,22.
//  4 Write/read race: m1 write addr 7 = 99 and m0 read addr 7 same cycle after m0 last
//    served -> m1 granted first, m0 next cycle, m0_rdata=99.
//  5 Withdraw: m1 req one cycle while m0 granted, then dropped -> no m1 gnt, no ram_we.
//  6 PERF_EN: 10 m0-only grants, 4 conflict cycles, perf_clr -> counts match
//    (gnt0, gnt1, wait), then 0; CNT_W=4 run of 20 grants saturates at 15.

Source files
------------

// File: rtl/sm_ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sm_ram_arbiter_pkg
// Shared definitions for the two-port sm_ram arbiter:
//   - owner codes for port 0 (CPU load/store) and port 1 (debug/loader)
//   - reset value of the round-robin last-owner flop
//   - rr_pick(): pure two-way round-robin grant function
// ----------------------------------------------------------------------------
package sm_ram_arbiter_pkg;

    localparam logic ARB_PORT0    = 1'b0;
    localparam logic ARB_PORT1    = 1'b1;
    // Port 1 is the reset owner so that port 0 wins the first conflict.
    localparam logic ARB_LAST_RST = ARB_PORT1;

    // One-hot grant for two requesters; on a conflict the port that did not
    // own the last grant wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_owner);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_owner == ARB_PORT1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/sm_ram_arbiter_rr2.sv
// ----------------------------------------------------------------------------
// sm_arb_rr2
// Two-way round-robin arbiter holding the last-owner flop.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset; grants forced low while low
//   req[1:0]   in   request per port
//   gnt[1:0]   out  one-hot grant, combinational from req
// ----------------------------------------------------------------------------
module sm_arb_rr2
    import sm_ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_owner_q;
    logic last_owner_d;

    always_comb begin
        gnt          = 2'b00;
        last_owner_d = last_owner_q;
        if (rst_n) begin
            gnt = rr_pick(req, last_owner_q);
        end
        if (gnt[1]) begin
            last_owner_d = ARB_PORT1;
        end else if (gnt[0]) begin
            last_owner_d = ARB_PORT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= ARB_LAST_RST;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/sm_ram_arbiter.sv
// ----------------------------------------------------------------------------
// sm_ram_arbiter
// Shares the single-port sm_ram (1-cycle synchronous read) between port 0
// (CPU load/store) and port 1 (debug/loader). Round-robin, one access per
// cycle, read data returned one cycle after the grant to the owning port only.
// Ports:
//   clk, rst_n                          clock / async active-low reset
//   mX_req, mX_we, mX_addr, mX_wdata    request fields, held until mX_gnt
//   mX_gnt                              combinational accept
//   mX_rvalid, mX_rdata                 registered read return (0 when not owner)
//   ram_addr, ram_wdata, ram_we         to sm_ram port A
//   ram_rdata                           from sm_ram q_a
// Optional feature, macro SM_RAM_ARB_PERF_EN:
//   perf_clr  in   synchronous clear of all counters (wins over increment)
//   perf_gnt0 out  saturating grant count, port 0
//   perf_gnt1 out  saturating grant count, port 1
//   perf_wait out  saturating count of cycles with a request left ungranted
// ----------------------------------------------------------------------------
module sm_ram_arbiter
    import sm_ram_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef SM_RAM_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
`ifdef SM_RAM_ARB_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_gnt0,
    output logic [CNT_W-1:0] perf_gnt1,
    output logic [CNT_W-1:0] perf_wait
`endif
);

    logic [1:0] gnt;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;
    logic       rd_grant;

    sm_arb_rr2 u_rr2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({m1_req, m0_req}),
        .gnt   (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Idle cycles present port 0 fields with the write strobe low.
    always_comb begin
        ram_addr   = m0_addr;
        ram_wdata  = m0_wdata;
        ram_we     = 1'b0;
        rd_grant   = 1'b0;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        if (gnt[1]) begin
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            ram_we    = m1_we;
            rd_grant  = !m1_we;
        end else if (gnt[0]) begin
            ram_we    = m0_we;
            rd_grant  = !m0_we;
        end
        if (rd_grant) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = gnt[1] ? ARB_PORT1 : ARB_PORT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= ARB_PORT0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read data is masked to zero for the non-owning port.
    assign m0_rvalid = rd_pend_q && (rd_owner_q == ARB_PORT0);
    assign m1_rvalid = rd_pend_q && (rd_owner_q == ARB_PORT1);
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

`ifdef SM_RAM_ARB_PERF_EN
    logic [CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
    logic [CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             wait_evt;

    assign wait_evt = (m0_req && !gnt[0]) || (m1_req && !gnt[1]);

    always_comb begin
        gnt0_cnt_d = gnt0_cnt_q;
        gnt1_cnt_d = gnt1_cnt_q;
        wait_cnt_d = wait_cnt_q;
        if (perf_clr) begin
            gnt0_cnt_d = '0;
            gnt1_cnt_d = '0;
            wait_cnt_d = '0;
        end else begin
            if (gnt[0] && (gnt0_cnt_q != '1)) gnt0_cnt_d = gnt0_cnt_q + 1'b1;
            if (gnt[1] && (gnt1_cnt_q != '1)) gnt1_cnt_d = gnt1_cnt_q + 1'b1;
            if (wait_evt && (wait_cnt_q != '1)) wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            gnt0_cnt_q <= gnt0_cnt_d;
            gnt1_cnt_q <= gnt1_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign perf_gnt0 = gnt0_cnt_q;
    assign perf_gnt1 = gnt1_cnt_q;
    assign perf_wait = wait_cnt_q;
`endif

endmodule
